// File: rtl/icache_sa.sv
// Set-associative instruction cache with LRU replacement, multi-word line fill and whole-cache
// invalidate. Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_sa #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SETS       = 4,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  input  logic              invalidate,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {StIdle, StLookup, StFillReq, StFillWait, StRespond} state_e;

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]  cnt_q;
  logic              victim_q;
  logic              flush_pending;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [SETS-1:0]   lru_q;

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS][LINE_WORDS];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic              hit;
  logic              hit_way;
  logic              victim;

  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign off = addr_q[OFF_W-1:0];

  assign req_ready = (state == StIdle) && !flush_pending && !invalidate;

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_mem[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Lowest invalid way first, otherwise the LRU way of the set.
  always_comb begin
    if (!valid_q[idx][0]) begin
      victim = 1'b0;
    end else if ((WAYS == 2) && !valid_q[idx][WAYS-1]) begin
      victim = 1'b1;
    end else begin
      victim = (WAYS == 2) ? lru_q[idx] : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      addr_q        <= '0;
      cnt_q         <= '0;
      victim_q      <= 1'b0;
      flush_pending <= 1'b0;
      valid_q       <= '{default: '0};
      lru_q         <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (invalidate && (state != StIdle)) flush_pending <= 1'b1;
      unique case (state)
        StIdle: begin
          if (invalidate || flush_pending) begin
            valid_q       <= '{default: '0};
            lru_q         <= '0;
            flush_pending <= 1'b0;
          end else if (req_valid) begin
            addr_q <= req_addr;
            state  <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_data  <= data_mem[hit_way][idx][off];
            if (WAYS == 2) lru_q[idx] <= ~hit_way;
            state <= StIdle;
          end else begin
            victim_q             <= victim;
            valid_q[idx][victim] <= 1'b0;
            cnt_q                <= '0;
            mem_req_valid        <= 1'b1;
            mem_req_addr         <= {tag, idx, {OFF_W{1'b0}}};
            state                <= StFillReq;
          end
        end
        StFillReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StFillWait;
          end
        end
        StFillWait: begin
          if (mem_resp_valid) begin
            if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
              valid_q[idx][victim_q] <= 1'b1;
              resp_valid             <= 1'b1;
              resp_hit               <= 1'b0;
              // The last word is still on the bus; earlier words are already in the array.
              resp_data <= (off == cnt_q) ? mem_resp_data : data_mem[victim_q][idx][off];
              state     <= StRespond;
            end else begin
              cnt_q         <= cnt_q + 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {tag, idx, cnt_q + 1'b1};
              state         <= StFillReq;
            end
          end
        end
        StRespond: begin
          if (WAYS == 2) lru_q[idx] <= ~victim_q;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == StLookup) && !hit) tag_mem[victim][idx] <= tag;
    if ((state == StFillWait) && mem_resp_valid) data_mem[victim_q][idx][cnt_q] <= mem_resp_data;
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == StLookup) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: recency-list cache model plus a backing store that
// returns 0x1000+address, with optional request stalls and stray responses.
module tb_icache_sa;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_hit;
  logic        invalidate = 1'b0;
  logic        mem_req_valid;
  logic [7:0]  mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  icache_sa dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_hit      (resp_hit),
    .invalidate    (invalidate),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_log[$];
  logic [7:0] stall_log[$];
  int         stall_left = 0;
  bit         stray_pending = 1'b0;

  // Backing store: accepts requests unless stalling, answers one cycle after the handshake.
  initial begin
    bit         pend;
    logic [7:0] pa;
    pend = 1'b0;
    pa = '0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (stray_pending) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = 16'hDEAD;
        stray_pending = 1'b0;
      end else if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = 16'h1000 + 16'(pa);
        pend = 1'b0;
      end
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
        stall_log.push_back(mem_req_addr);
      end else begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          mem_log.push_back(mem_req_addr);
          pend = 1'b1;
          pa = mem_req_addr;
        end
      end
    end
  end

  // Reference model: per set, resident tags ordered most-recently-used first.
  int         m_n[4];
  logic [3:0] m_t[4][2];
  int         m_hits = 0;
  int         m_misses = 0;

  function automatic void model_clear();
    for (int s = 0; s < 4; s++) m_n[s] = 0;
  endfunction

  function automatic bit model_access(input logic [7:0] a);
    int s;
    s = int'(a[3:2]);
    for (int i = 0; i < m_n[s]; i++) begin
      if (m_t[s][i] == a[7:4]) begin
        for (int j = i; j > 0; j--) m_t[s][j] = m_t[s][j-1];
        m_t[s][0] = a[7:4];
        m_hits++;
        return 1'b1;
      end
    end
    if (m_n[s] < 2) m_n[s]++;
    for (int j = m_n[s] - 1; j > 0; j--) m_t[s][j] = m_t[s][j-1];
    m_t[s][0] = a[7:4];
    m_misses++;
    return 1'b0;
  endfunction

  // Issues one fetch; lat is the cycle (accept cycle = 0) in which resp_valid is seen.
  task automatic access(input logic [7:0] a, output logic [15:0] d, output logic h,
                        output int lat, output int nreq, output time t_resp);
    int n0;
    n0 = mem_log.size();
    d = 'x;
    h = 1'bx;
    lat = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    #1;
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (resp_valid) begin
        lat = c;
        d = resp_data;
        h = resp_hit;
        break;
      end
      @(posedge clk);
      #1;
    end
    t_resp = $time;
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout addr %h: no resp_valid within bound", a);
    end
    nreq = mem_log.size() - n0;
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    model_clear();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    stall_left = 0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic test_reset();
    logic [59:0] obs;
    #2;
    obs = {req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr,
           hit_count, miss_count};
    n_tests++;
    if (obs !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, {1'b1, 59'h0});
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_cold_miss();
    logic [15:0] d;
    logic h;
    int lat, nreq, n0;
    time t;
    n0 = mem_log.size();
    void'(model_access(8'h25));
    access(8'h25, d, h, lat, nreq, t);
    n_tests++;
    if ({h, d} !== {1'b0, 16'h1025}) begin
      n_fail++;
      $display("FAIL cold_miss_resp: got hit=%b data=%h want hit=0 data=1025", h, d);
    end
    n_tests++;
    if (nreq !== 4) begin
      n_fail++;
      $display("FAIL cold_miss_nreq: got %0d want 4", nreq);
    end
    for (int i = 0; i < 4 && i < nreq; i++) begin
      n_tests++;
      if (mem_log[n0+i] !== 8'h24 + 8'(i)) begin
        n_fail++;
        $display("FAIL cold_miss_addr%0d: got %h want %h", i, mem_log[n0+i], 8'h24 + 8'(i));
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_pulse_width: got resp_valid=%b want 0", resp_valid);
    end
    void'(model_access(8'h26));
    access(8'h26, d, h, lat, nreq, t);
    n_tests++;
    if ({h, d, lat, nreq} !== {1'b1, 16'h1026, 32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL hit_after_fill: got hit=%b data=%h lat=%0d nreq=%0d want 1 1026 2 0",
               h, d, lat, nreq);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d1, d2;
    logic h1, h2;
    int lat, nreq;
    time t1, t2;
    void'(model_access(8'h25));
    void'(model_access(8'h27));
    access(8'h25, d1, h1, lat, nreq, t1);
    access(8'h27, d2, h2, lat, nreq, t2);
    n_tests++;
    if ({h1, d1, h2, d2} !== {1'b1, 16'h1025, 1'b1, 16'h1027}) begin
      n_fail++;
      $display("FAIL b2b_data: got %b %h %b %h want 1 1025 1 1027", h1, d1, h2, d2);
    end
    n_tests++;
    if (t2 - t1 !== 20) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0t want 20", t2 - t1);
    end
  endtask

  task automatic test_conflict();
    logic [7:0] addrs[6] = '{8'h04, 8'h44, 8'h04, 8'h84, 8'h04, 8'h44};
    bit         exp_h[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] d;
    logic h;
    int lat, nreq, n0;
    time t;
    for (int i = 0; i < 6; i++) begin
      void'(model_access(addrs[i]));
      n0 = mem_log.size();
      access(addrs[i], d, h, lat, nreq, t);
      n_tests++;
      if ({h, d, nreq} !== {exp_h[i], 16'h1000 + 16'(addrs[i]), exp_h[i] ? 32'd0 : 32'd4}) begin
        n_fail++;
        $display("FAIL conflict_%0d(%h): got hit=%b data=%h nreq=%0d want hit=%b", i, addrs[i],
                 h, d, nreq, exp_h[i]);
      end
    end
    n_tests++;
    if (mem_log[n0+3] !== 8'h47) begin
      n_fail++;
      $display("FAIL conflict_refill_last: got %h want 47", mem_log[n0+3]);
    end
  endtask

  task automatic test_invalidate();
    logic [15:0] d;
    logic h;
    int lat, nreq;
    time t;
    bit seen;
    @(negedge clk);
    invalidate = 1'b1;
    req_valid = 1'b1;
    req_addr = 8'h04;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_req_ready: got %b want 0", req_ready);
    end
    @(negedge clk);
    invalidate = 1'b0;
    req_valid = 1'b0;
    model_clear();
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_req_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_no_accept: got activity=%b want 0", seen);
    end
    void'(model_access(8'h25));
    access(8'h25, d, h, lat, nreq, t);
    n_tests++;
    if ({h, d, nreq} !== {1'b0, 16'h1025, 32'd4}) begin
      n_fail++;
      $display("FAIL inv_then_miss: got hit=%b data=%h nreq=%0d want 0 1025 4", h, d, nreq);
    end
    // Invalidate pulsed while the fill is in flight.
    void'(model_access(8'h16));
    fork
      access(8'h16, d, h, lat, nreq, t);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          #1;
          if (mem_req_valid) break;
        end
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
      end
    join
    model_clear();
    n_tests++;
    if ({h, d, nreq} !== {1'b0, 16'h1016, 32'd4}) begin
      n_fail++;
      $display("FAIL inv_mid_fill_resp: got hit=%b data=%h nreq=%0d want 0 1016 4", h, d, nreq);
    end
    void'(model_access(8'h16));
    access(8'h16, d, h, lat, nreq, t);
    n_tests++;
    if ({h, d, nreq} !== {1'b0, 16'h1016, 32'd4}) begin
      n_fail++;
      $display("FAIL inv_mid_fill_after: got hit=%b data=%h nreq=%0d want 0 1016 4", h, d, nreq);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic h;
    int lat, nreq, n0;
    time t;
    stall_log.delete();
    void'(model_access(8'h9B));
    n0 = mem_log.size();
    stall_left = 5;
    access(8'h9B, d, h, lat, nreq, t);
    n_tests++;
    if ({h, d, nreq, stall_left, stall_log.size()} !== {1'b0, 16'h109B, 32'd4, 32'd0, 32'd5}) begin
      n_fail++;
      $display("FAIL bp_resp: got hit=%b data=%h nreq=%0d stall_left=%0d stalled=%0d want 0 109b 4 0 5",
               h, d, nreq, stall_left, stall_log.size());
    end
    for (int i = 0; i < stall_log.size(); i++) begin
      n_tests++;
      if (stall_log[i] !== 8'h98) begin
        n_fail++;
        $display("FAIL bp_addr_stable%0d: got %h want 98", i, stall_log[i]);
      end
    end
    n_tests++;
    if (mem_log[n0+3] !== 8'h9B) begin
      n_fail++;
      $display("FAIL bp_last_addr: got %h want 9b", mem_log[n0+3]);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] d;
    logic h;
    int lat, nreq;
    time t;
    bit busy;
    logic [59:0] obs;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 8'h30;
    #1;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_resp_valid) begin
        busy = 1'b1;
        break;
      end
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fill_reach: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    obs = {req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr,
           hit_count, miss_count};
    n_tests++;
    if (obs !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_fill_outputs: got %h want %h", obs, {1'b1, 59'h0});
    end
    stray_pending = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
    busy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_req_valid) busy = 1'b1;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray_ignored: got activity=%b want 0", busy);
    end
    void'(model_access(8'h30));
    access(8'h30, d, h, lat, nreq, t);
    n_tests++;
    if ({h, d, nreq} !== {1'b0, 16'h1030, 32'd4}) begin
      n_fail++;
      $display("FAIL rst_refetch: got hit=%b data=%h nreq=%0d want 0 1030 4", h, d, nreq);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [15:0] d;
    logic h;
    bit eh;
    int lat, nreq, n0, r;
    time t;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        pulse_inv();
        continue;
      end
      a[7:4] = 4'($urandom_range(0, 2));
      a[3:0] = 4'($urandom_range(0, 15));
      eh = model_access(a);
      if (!eh && r == 1) stall_left = int'($urandom_range(1, 4));
      n0 = mem_log.size();
      access(a, d, h, lat, nreq, t);
      n_tests++;
      if ({h, d, nreq} !== {eh, 16'h1000 + 16'(a), eh ? 32'd0 : 32'd4}) begin
        n_fail++;
        $display("FAIL rand_%0d(%h): got hit=%b data=%h nreq=%0d want hit=%b data=%h",
                 it, a, h, d, nreq, eh, 16'h1000 + 16'(a));
      end
      if (!eh && nreq == 4) begin
        n_tests++;
        if (mem_log[n0] !== {a[7:2], 2'b00}) begin
          n_fail++;
          $display("FAIL rand_%0d_base: got %h want %h", it, mem_log[n0], {a[7:2], 2'b00});
        end
      end
    end
    n_tests++;
    if ({hit_count, miss_count} !== (STATS ? {16'(m_hits), 16'(m_misses)} : 32'h0)) begin
      n_fail++;
      $display("FAIL rand_counters: got %0d/%0d want %0d/%0d (stats=%b)", hit_count, miss_count,
               m_hits, m_misses, STATS);
    end
  endtask

  task automatic test_stats();
    logic [7:0] seq[5] = '{8'h50, 8'h50, 8'h51, 8'h60, 8'h61};
    logic [15:0] d;
    logic h;
    int lat, nreq;
    time t;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      void'(model_access(seq[i]));
      access(seq[i], d, h, lat, nreq, t);
    end
    pulse_inv();
    n_tests++;
    if ({hit_count, miss_count} !== (STATS ? {16'd3, 16'd2} : 32'h0)) begin
      n_fail++;
      $display("FAIL stats_3h2m: got %0d/%0d want %0d/%0d", hit_count, miss_count,
               STATS ? 3 : 0, STATS ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_backpressure();
    test_reset_mid_fill();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
